// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer: keeps the fetch address, predicts the next PC, and
// tracks run / return-wait / halt / error status for the fetch stage.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valC_i,
    input  logic [63:0] valP_i,
    input  logic        instr_valid_i,
    input  logic        imem_error_i,
    input  logic        stall_i,
    input  logic        mispredict_i,
    input  logic [63:0] mispredict_pc_i,
    input  logic        ret_valid_i,
    input  logic [63:0] ret_pc_i,
    output logic [63:0] pc_o,
    output logic        fetch_valid_o,
    output logic [63:0] pred_pc_o,
    output logic [2:0]  stat_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [1:0] {
        S_RUN,
        S_RET_WAIT,
        S_HALT,
        S_ERR
    } state_e;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [2:0]  stat_q, stat_d;
    logic [31:0] count_q, count_d;
    logic        fetch_accept;

    // Jumps and calls are predicted taken; everything else falls through.
    assign pred_pc_o     = (icode_i == IC_JXX || icode_i == IC_CALL) ? valC_i : valP_i;
    assign fetch_accept  = (state_q == S_RUN) && !stall_i && !mispredict_i;
    assign fetch_valid_o = fetch_accept;
    assign pc_o          = pc_q;
    assign stat_o        = stat_q;
    assign fetch_count_o = count_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stat_d  = stat_q;
        count_d = count_q;
        if (mispredict_i) begin
            pc_d    = mispredict_pc_i;
            state_d = S_RUN;
            stat_d  = STAT_AOK;
        end else begin
            case (state_q)
                S_RET_WAIT: begin
                    if (ret_valid_i) begin
                        pc_d    = ret_pc_i;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (fetch_accept) begin
                        // A bad address outranks an illegal opcode.
                        if (imem_error_i) begin
                            state_d = S_ERR;
                            stat_d  = STAT_ADR;
                        end else if (!instr_valid_i) begin
                            state_d = S_ERR;
                            stat_d  = STAT_INS;
                        end else begin
                            count_d = count_q + 32'd1;
                            if (icode_i == IC_HALT) begin
                                state_d = S_HALT;
                                stat_d  = STAT_HLT;
                            end else if (icode_i == IC_RET) begin
                                state_d = S_RET_WAIT;
                            end else begin
                                pc_d = pred_pc_o;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a directed vector table for the corner sequences,
// then randomized cycles compared against a behavioural model.
module tb_pc_sequencer;

    localparam logic [63:0] R = 64'h1000;

    logic        clk;
    logic        rst_i;
    logic [3:0]  icode_i;
    logic [63:0] valC_i;
    logic [63:0] valP_i;
    logic        instr_valid_i;
    logic        imem_error_i;
    logic        stall_i;
    logic        mispredict_i;
    logic [63:0] mispredict_pc_i;
    logic        ret_valid_i;
    logic [63:0] ret_pc_i;
    logic [63:0] pc_o;
    logic        fetch_valid_o;
    logic [63:0] pred_pc_o;
    logic [2:0]  stat_o;
    logic [31:0] fetch_count_o;

    pc_sequencer #(.RESET_PC(R)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .icode_i         (icode_i),
        .valC_i          (valC_i),
        .valP_i          (valP_i),
        .instr_valid_i   (instr_valid_i),
        .imem_error_i    (imem_error_i),
        .stall_i         (stall_i),
        .mispredict_i    (mispredict_i),
        .mispredict_pc_i (mispredict_pc_i),
        .ret_valid_i     (ret_valid_i),
        .ret_pc_i        (ret_pc_i),
        .pc_o            (pc_o),
        .fetch_valid_o   (fetch_valid_o),
        .pred_pc_o       (pred_pc_o),
        .stat_o          (stat_o),
        .fetch_count_o   (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  icode;
        logic [63:0] valc, valp;
        logic        iv, ie, stall, mp;
        logic [63:0] mpc;
        logic        rv;
        logic [63:0] rpc;
        logic        pre;
        logic        exp_fv;
        logic [63:0] exp_pred, exp_pc;
        logic [2:0]  exp_stat;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Behavioural model: status word plus a "waiting for return" flag.
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic [31:0] m_cnt;
    bit          m_wait;
    bit          m_known = 0;

    function automatic vec_t mk(logic rst, logic [3:0] icode, logic [63:0] valc, logic [63:0] valp,
                                logic iv, logic ie, logic stall, logic mp, logic [63:0] mpc,
                                logic rv, logic [63:0] rpc, logic pre, logic fv, logic [63:0] pred,
                                logic [63:0] pc, logic [2:0] stat, logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.icode = icode; v.valc = valc; v.valp = valp;
        v.iv = iv; v.ie = ie; v.stall = stall; v.mp = mp; v.mpc = mpc;
        v.rv = rv; v.rpc = rpc; v.pre = pre; v.exp_fv = fv; v.exp_pred = pred;
        v.exp_pc = pc; v.exp_stat = stat; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl);
        logic        m_fv;
        logic [63:0] m_pred;
        rst_i = v.rst; icode_i = v.icode; valC_i = v.valc; valP_i = v.valp;
        instr_valid_i = v.iv; imem_error_i = v.ie; stall_i = v.stall;
        mispredict_i = v.mp; mispredict_pc_i = v.mpc; ret_valid_i = v.rv; ret_pc_i = v.rpc;
        m_fv   = m_known && !m_wait && (m_stat == 3'd1) && !v.stall && !v.mp;
        m_pred = (v.icode == 4'h7 || v.icode == 4'h8) ? v.valc : v.valp;
        @(negedge clk);
        if (use_tbl) begin
            if (v.pre) begin
                chk("fetch_valid", {63'd0, fetch_valid_o}, {63'd0, v.exp_fv});
                chk("pred_pc", pred_pc_o, v.exp_pred);
            end
        end else begin
            chk("fetch_valid", {63'd0, fetch_valid_o}, {63'd0, m_fv});
            chk("pred_pc", pred_pc_o, m_pred);
        end
        @(posedge clk);
        if (v.rst) begin
            m_pc = R; m_stat = 3'd1; m_cnt = 0; m_wait = 0; m_known = 1;
        end else if (v.mp) begin
            m_pc = v.mpc; m_stat = 3'd1; m_wait = 0;
        end else if (m_wait) begin
            if (v.rv) begin
                m_pc = v.rpc; m_wait = 0;
            end
        end else if (m_fv) begin
            if (v.ie) m_stat = 3'd3;
            else if (!v.iv) m_stat = 3'd4;
            else begin
                m_cnt = m_cnt + 1;
                if (v.icode == 4'h0) m_stat = 3'd2;
                else if (v.icode == 4'h9) m_wait = 1;
                else m_pc = m_pred;
            end
        end
        #1;
        if (use_tbl) begin
            chk("pc", pc_o, v.exp_pc);
            chk("stat", {61'd0, stat_o}, {61'd0, v.exp_stat});
            chk("count", {32'd0, fetch_count_o}, {32'd0, v.exp_cnt});
        end else begin
            chk("pc", pc_o, m_pc);
            chk("stat", {61'd0, stat_o}, {61'd0, m_stat});
            chk("count", {32'd0, fetch_count_o}, {32'd0, m_cnt});
        end
        cyc++;
    endtask

    initial begin
        vec_t rv_v;
        logic [3:0] ic;
        rst_i = 1; icode_i = 0; valC_i = 0; valP_i = 0; instr_valid_i = 1; imem_error_i = 0;
        stall_i = 0; mispredict_i = 0; mispredict_pc_i = 0; ret_valid_i = 0; ret_pc_i = 0;
        @(posedge clk); #1;

        //         rst icode valC    valP    iv ie st mp mpc     rv rpc     pre fv pred    pc      st cnt
        tbl.push_back(mk(1, 4'h3, 64'h99, 64'hA,  1, 0, 0, 0, 64'h0,  0, 64'h0,  0, 0, 64'hA,  R,      1, 0));
        tbl.push_back(mk(0, 4'h3, 64'h99, 64'hA,  1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'hA,  64'hA,  1, 1));
        tbl.push_back(mk(0, 4'h6, 64'h99, 64'hC,  1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'hC,  64'hC,  1, 2));
        tbl.push_back(mk(0, 4'h7, 64'h14, 64'h15, 1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h14, 64'h14, 1, 3));
        tbl.push_back(mk(0, 4'h7, 64'h40, 64'h1D, 1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h40, 64'h40, 1, 4));
        tbl.push_back(mk(0, 4'h3, 64'h0,  64'h49, 1, 0, 0, 1, 64'h1E, 0, 64'h0,  1, 0, 64'h49, 64'h1E, 1, 4));
        tbl.push_back(mk(0, 4'h8, 64'h22, 64'h27, 1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h22, 64'h22, 1, 5));
        tbl.push_back(mk(0, 4'h9, 64'h0,  64'h23, 1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h23, 64'h22, 1, 6));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 4'h9, 64'h0, 64'h23, 1, 0, 0, 0, 64'h0, 0, 64'h0, 1, 0, 64'h23, 64'h22, 1, 6));
        tbl.push_back(mk(0, 4'h9, 64'h0,  64'h23, 1, 0, 1, 0, 64'h0,  1, 64'h30, 1, 0, 64'h23, 64'h30, 1, 6));
        tbl.push_back(mk(0, 4'h0, 64'h0,  64'h31, 1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h31, 64'h30, 2, 7));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'h0, 64'h0, 64'h31, 1, 0, 0, 0, 64'h0, logic'(i % 2 == 0), 64'h77,
                             1, 0, 64'h31, 64'h30, 2, 7));
        tbl.push_back(mk(0, 4'h0, 64'h0,  64'h31, 1, 0, 1, 1, 64'h50, 0, 64'h0,  1, 0, 64'h31, 64'h50, 1, 7));
        tbl.push_back(mk(0, 4'hD, 64'h0,  64'h51, 0, 1, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h51, 64'h50, 3, 7));
        tbl.push_back(mk(0, 4'h3, 64'h0,  64'h51, 1, 0, 0, 1, 64'h60, 0, 64'h0,  1, 0, 64'h51, 64'h60, 1, 7));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 4'h3, 64'h0, 64'h6A, 1, 0, 1, 0, 64'h0, 0, 64'h0, 1, 0, 64'h6A, 64'h60, 1, 7));
        tbl.push_back(mk(0, 4'hE, 64'h0,  64'h61, 0, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h61, 64'h60, 4, 7));
        tbl.push_back(mk(0, 4'h3, 64'h0,  64'h61, 1, 0, 0, 1, 64'h70, 0, 64'h0,  1, 0, 64'h61, 64'h70, 1, 7));
        tbl.push_back(mk(0, 4'h9, 64'h0,  64'h72, 1, 0, 0, 0, 64'h0,  0, 64'h0,  1, 1, 64'h72, 64'h70, 1, 8));
        tbl.push_back(mk(1, 4'h9, 64'h0,  64'h72, 1, 0, 0, 1, 64'h99, 1, 64'h88, 1, 0, 64'h72, R,      1, 0));
        tbl.push_back(mk(0, 4'h3, 64'h0,  64'h1005, 1, 0, 0, 0, 64'h0, 0, 64'h0, 1, 1, 64'h1005, 64'h1005, 1, 1));
        tbl.push_back(mk(0, 4'h4, 64'h0,  64'h1010, 1, 0, 0, 0, 64'h0, 1, 64'hBAD, 1, 1, 64'h1010, 64'h1010, 1, 2));

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        for (int i = 0; i < 3000; i++) begin
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            rv_v = mk($urandom_range(0, 63) == 0, ic, {$urandom, $urandom}, {$urandom, $urandom},
                      ic < 4'hC, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 11) == 0, {$urandom, $urandom},
                      $urandom_range(0, 2) == 0, {$urandom, $urandom},
                      0, 0, 64'h0, 64'h0, 3'd0, 32'd0);
            run_cycle(rv_v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
